// File: rtl/uart_rx_if.sv
// uart_if: serial line plus valid/ready word bundle between
// the UART receiver and its consumer.
interface uart_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sig;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport rx (
    input  sig,
    input  ready,
    output data,
    output valid
  );

  modport sink (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 1 start / DATA_WIDTH data (LSB first) / 1 stop receiver.
// Optional UART_RX_STOP_CHECK_EN drops frames whose stop bit is low.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 100_000_000
) (
  input logic clk,
  input logic rstn,
  uart_if.rx  rxif
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [IW-1:0] LAST     = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_n;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_n;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  accept;
  logic                  stop_ok;
  logic                  s1;
  logic                  rx;

  // Preset to 1 so reset looks like an idle line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b1;
      rx <= 1'b1;
    end else begin
      s1 <= rxif.sig;
      rx <= s1;
    end
  end

`ifdef UART_RX_STOP_CHECK_EN
  assign stop_ok = rx;
`else
  assign stop_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx) begin
          state_n = START;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n   = '0;
          state_n = rx ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n        = '0;
          shreg_n[idx] = rx;
          if (idx == LAST) state_n = STOP;
          else             idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          state_n = IDLE;
          accept  = stop_ok;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  // A new word wins over a same-cycle ready: valid stays up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      data_q  <= shreg_n;
      valid_q <= 1'b1;
    end else if (valid_q && rxif.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign rxif.data  = data_q;
  assign rxif.valid = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit.
// Bad-stop expectation follows UART_RX_STOP_CHECK_EN.
module tb_uart_rx;

  localparam int DW   = 8;
  localparam int BAUD = 10;
  localparam int CLKF = 160;
  localparam int CPB  = CLKF / BAUD;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx #(
    .DATA_WIDTH(DW),
    .BAUD_RATE (BAUD),
    .CLK_FREQ  (CLKF)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .rxif(bus)
  );

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk) bus.sig = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      bus.sig = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.sig = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pulse_ready();
    @(negedge clk) bus.ready = 1'b1;
    @(negedge clk) bus.ready = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rstn      = 1'b0;
    bus.sig   = 1'b1;
    bus.ready = 1'b0;
    repeat (100) @(negedge clk);
    tests++;
    if (bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b want 0", bus.valid);
    end
    tests++;
    if (bus.data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %h want 00", bus.data);
    end
    rstn = 1'b1;
    seen = 0;
    repeat (20 * CPB) begin
      @(negedge clk);
      if (bus.valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL idle_no_valid: valid cycles %0d want 0", seen);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] b;
    for (int k = 0; k < 256; k++) begin
      b = k[7:0];
      send_frame(b, 1'b1);
      repeat ($urandom_range(0, CPB / 4)) @(negedge clk);
      tests++;
      if (bus.valid !== 1'b1 || bus.data !== b) begin
        fails++;
        $display("FAIL sweep_%h: valid=%b data=%h want valid=1 data=%h",
                 b, bus.valid, bus.data, b);
      end
      pulse_ready();
      tests++;
      if (bus.valid !== 1'b0) begin
        fails++;
        $display("FAIL sweep_clr_%h: valid=%b want 0", b, bus.valid);
      end
    end
  endtask

  task automatic test_hold();
    int bad;
    send_frame(8'hA5, 1'b1);
    bad = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (bus.valid !== 1'b1 || bus.data !== 8'hA5) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold: %0d bad cycles, last valid=%b data=%h want 1/a5",
               bad, bus.valid, bus.data);
    end
    pulse_ready();
    tests++;
    if (bus.valid !== 1'b0 || bus.data !== 8'hA5) begin
      fails++;
      $display("FAIL hold_clr: valid=%b data=%h want 0/a5",
               bus.valid, bus.data);
    end
  endtask

  task automatic test_glitch();
    int seen;
    @(negedge clk) bus.sig = 1'b0;
    repeat (2) @(negedge clk);
    bus.sig = 1'b1;
    seen = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (bus.valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL glitch_no_valid: valid cycles %0d want 0", seen);
    end
    send_frame(8'h3C, 1'b1);
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h3C) begin
      fails++;
      $display("FAIL glitch_next: valid=%b data=%h want 1/3c",
               bus.valid, bus.data);
    end
    pulse_ready();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h22) begin
      fails++;
      $display("FAIL overrun: valid=%b data=%h want 1/22",
               bus.valid, bus.data);
    end
    pulse_ready();
    tests++;
    if (bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clr: valid=%b want 0", bus.valid);
    end
    pulse_ready();
    send_frame(8'h96, 1'b1);
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h96) begin
      fails++;
      $display("FAIL ready_idle: valid=%b data=%h want 1/96",
               bus.valid, bus.data);
    end
    pulse_ready();
  endtask

  task automatic test_bad_stop();
    send_frame(8'h5A, 1'b0);
    bus.sig = 1'b1;
    repeat (2 * CPB) @(negedge clk);
`ifdef UART_RX_STOP_CHECK_EN
    tests++;
    if (bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL bad_stop: valid=%b want 0", bus.valid);
    end
`else
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h5A) begin
      fails++;
      $display("FAIL bad_stop: valid=%b data=%h want 1/5a",
               bus.valid, bus.data);
    end
    pulse_ready();
`endif
  endtask

  task automatic test_reset_mid();
    send_frame(8'h42, 1'b1);
    @(negedge clk) bus.sig = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.sig = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    rstn = 1'b0;
    #2;
    tests++;
    if (bus.valid !== 1'b0 || bus.data !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid: valid=%b data=%h want 0/00",
               bus.valid, bus.data);
    end
    repeat (10) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h81, 1'b1);
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h81) begin
      fails++;
      $display("FAIL reset_mid_next: valid=%b data=%h want 1/81",
               bus.valid, bus.data);
    end
    pulse_ready();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sig   = 1'b1;
    bus.ready = 1'b0;
    test_reset();
    test_sweep();
    test_hold();
    test_glitch();
    test_back_to_back();
    test_bad_stop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
